mem_access_unit: RTL and testbench

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs and performs word, halfword and byte accesses to a single-port synchronous data RAM. Loads and sub-word stores each take two cycles and freeze the front of the pipeline for one cycle. Formatted load data and a misalignment flag are presented to the MEM/WB register.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/data_ram.sv | 22 ++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_DATA   = 2'd1,
        STORE_MERGE = 2'd2
    } memState_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } accessSize_e;

    // Byte wins over halfword when both are flagged.
    function automatic accessSize_e decodeSize(input logic isByte, input logic isHalf);
        if (isByte) begin
            return SZ_BYTE;
        end else if (isHalf) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM, 32-bit words, registered read-first output.
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              Clk,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (writeEnable) begin
            mem[address] <= writeData;
        end
        readData <= mem[address];
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word/half/byte accesses to a synchronous RAM, with a
// one-cycle front-end stall for loads and read-modify-write sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inMemByte,
    input  logic        inMemHalf,
    input  logic [31:0] inAddress,
    input  logic [31:0] inWriteData,
    output logic [31:0] outReadData,
    output logic        outStall,
    output logic        outMisaligned
);

    memState_e   stateQ, stateD;
    accessSize_e accessSize;
    logic        accessReq;
    logic        misalignedAccess;
    logic        ramWe;
    logic [31:0] ramWdata;
    logic [31:0] ramOut;
    logic [31:0] loadData;
    logic [31:0] mergedData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        unusedAddrBits;

    // Upper address bits are deliberately dropped so accesses wrap modulo RAM size.
    assign unusedAddrBits = ^inAddress[31:ADDR_W+2];

    assign accessSize = decodeSize(inMemByte, inMemHalf);
    assign accessReq  = inMemRead | inMemWrite;

    always_comb begin
        misalignedAccess = 1'b0;
        if (accessSize == SZ_HALF) begin
            misalignedAccess = inAddress[0];
        end else if (accessSize == SZ_WORD) begin
            misalignedAccess = (inAddress[1:0] != 2'b00);
        end
    end

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) uRam (
        .Clk        (Clk),
        .writeEnable(ramWe),
        .address    (inAddress[ADDR_W+1:2]),
        .writeData  (ramWdata),
        .readData   (ramOut)
    );

    // Little-endian lane select, sign extension and sub-word merge.
    always_comb begin
        byteSel    = ramOut[{inAddress[1:0], 3'b000} +: 8];
        halfSel    = inAddress[1] ? ramOut[31:16] : ramOut[15:0];
        loadData   = ramOut;
        mergedData = ramOut;
        if (accessSize == SZ_BYTE) begin
            loadData = {{24{byteSel[7]}}, byteSel};
            mergedData[{inAddress[1:0], 3'b000} +: 8] = inWriteData[7:0];
        end else if (accessSize == SZ_HALF) begin
            loadData = {{16{halfSel[15]}}, halfSel};
            mergedData[{inAddress[1], 4'b0000} +: 16] = inWriteData[15:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (accessReq && !misalignedAccess) begin
                    if (inMemWrite) begin
                        if (accessSize != SZ_WORD) begin
                            stateD = STORE_MERGE;
                        end
                    end else begin
                        stateD = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA:   stateD = IDLE;
            STORE_MERGE: stateD = IDLE;
            default:     stateD = IDLE;
        endcase
    end

    always_comb begin
        outStall      = 1'b0;
        outMisaligned = 1'b0;
        outReadData   = 32'd0;
        ramWe         = 1'b0;
        ramWdata      = inWriteData;
        unique case (stateQ)
            IDLE: begin
                if (accessReq) begin
                    if (misalignedAccess) begin
                        outMisaligned = 1'b1;
                    end else if (inMemWrite && accessSize == SZ_WORD) begin
                        ramWe = 1'b1;
                    end else begin
                        outStall = 1'b1;
                    end
                end
            end
            LOAD_DATA: begin
                outReadData = loadData;
            end
            STORE_MERGE: begin
                ramWe    = 1'b1;
                ramWdata = mergedData;
            end
            default: begin
            end
        endcase
        // A reset edge must never commit a write, including an in-flight merge.
        if (Reset) begin
            ramWe = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    localparam int unsigned Depth = 64;
    localparam int unsigned AddrW = $clog2(Depth);

    logic        Clk = 1'b0;
    logic        Reset;
    logic        inMemRead;
    logic        inMemWrite;
    logic        inMemByte;
    logic        inMemHalf;
    logic [31:0] inAddress;
    logic [31:0] inWriteData;
    logic [31:0] outReadData;
    logic        outStall;
    logic        outMisaligned;

    int compared   = 0;
    int mismatched = 0;

    mem_access_unit #(
        .DEPTH_WORDS(Depth),
        .ADDR_W     (AddrW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .inMemRead    (inMemRead),
        .inMemWrite   (inMemWrite),
        .inMemByte    (inMemByte),
        .inMemHalf    (inMemHalf),
        .inAddress    (inAddress),
        .inWriteData  (inWriteData),
        .outReadData  (outReadData),
        .outStall     (outStall),
        .outMisaligned(outMisaligned)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic by, input logic hf,
                         input logic [31:0] addr, input logic [31:0] data);
        inMemRead   = rd;
        inMemWrite  = wr;
        inMemByte   = by;
        inMemHalf   = hf;
        inAddress   = addr;
        inWriteData = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic storeWord(input string tag, input logic [31:0] addr, input logic [31:0] data);
        drive(1'b0, 1'b1, 1'b0, 1'b0, addr, data);
        #1;
        check({tag, ".stall"}, {31'd0, outStall}, 32'd0);
        tick();
        idle();
    endtask

    task automatic storeSub(input string tag, input logic by, input logic hf,
                            input logic [31:0] addr, input logic [31:0] data);
        drive(1'b0, 1'b1, by, hf, addr, data);
        #1;
        check({tag, ".stall1"}, {31'd0, outStall}, 32'd1);
        tick();
        #1;
        check({tag, ".stall2"}, {31'd0, outStall}, 32'd0);
        check({tag, ".rdata2"}, outReadData, 32'd0);
        tick();
        idle();
    endtask

    task automatic load(input string tag, input logic by, input logic hf,
                        input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b1, 1'b0, by, hf, addr, 32'd0);
        #1;
        check({tag, ".stall1"}, {31'd0, outStall}, 32'd1);
        check({tag, ".rdata1"}, outReadData, 32'd0);
        tick();
        #1;
        check({tag, ".stall2"}, {31'd0, outStall}, 32'd0);
        check({tag, ".rdata2"}, outReadData, exp);
        tick();
        idle();
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        tick();
        tick();
        #1;
        check("reset.stall", {31'd0, outStall}, 32'd0);
        check("reset.mis", {31'd0, outMisaligned}, 32'd0);
        check("reset.rdata", outReadData, 32'd0);
        Reset = 1'b0;
        tick();

        // Word store then load
        storeWord("sw10", 32'h10, 32'hDEADBEEF);
        load("lw10", 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);

        // Byte merge
        storeWord("sw20", 32'h20, 32'h11223344);
        storeSub("sb22", 1'b1, 1'b0, 32'h22, 32'h000000AA);
        load("lw20", 1'b0, 1'b0, 32'h20, 32'h11AA3344);
        load("lb22", 1'b1, 1'b0, 32'h22, 32'hFFFFFFAA);
        load("lb20", 1'b1, 1'b0, 32'h20, 32'h00000044);
        // Byte flag wins over half flag: byte lane 3 of 0x11AA3344
        load("lbh23", 1'b1, 1'b1, 32'h23, 32'h00000011);

        // Halfword merge, upper store-data bits ignored
        storeWord("sw30", 32'h30, 32'h12345678);
        storeSub("sh32", 1'b0, 1'b1, 32'h32, 32'hABCD8001);
        load("lw30", 1'b0, 1'b0, 32'h30, 32'h80015678);
        load("lh32", 1'b0, 1'b1, 32'h32, 32'hFFFF8001);
        load("lh30", 1'b0, 1'b1, 32'h30, 32'h00005678);

        // Misaligned accesses are suppressed
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h13, 32'd0);
        #1;
        check("mislh13.mis", {31'd0, outMisaligned}, 32'd1);
        check("mislh13.stall", {31'd0, outStall}, 32'd0);
        check("mislh13.rdata", outReadData, 32'd0);
        tick();
        idle();
        #1;
        check("mislh13.after", outReadData, 32'd0);
        check("mislh13.pulse", {31'd0, outMisaligned}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0BADF00D);
        #1;
        check("missw12.mis", {31'd0, outMisaligned}, 32'd1);
        check("missw12.stall", {31'd0, outStall}, 32'd0);
        tick();
        idle();
        load("lw10b", 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'd0);
        #1;
        check("mislw11.mis", {31'd0, outMisaligned}, 32'd1);
        tick();
        idle();

        // Reset during STORE_MERGE aborts the write
        storeWord("sw40", 32'h40, 32'hCAFEBABE);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h00000055);
        #1;
        check("rst.stall1", {31'd0, outStall}, 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        idle();
        #1;
        check("rst.stall", {31'd0, outStall}, 32'd0);
        check("rst.mis", {31'd0, outMisaligned}, 32'd0);
        check("rst.rdata", outReadData, 32'd0);
        tick();
        load("lw40", 1'b0, 1'b0, 32'h40, 32'hCAFEBABE);

        // Address wrap: Depth*4+8 maps to word index 2
        storeWord("swwrap", Depth * 4 + 8, 32'h600DCAFE);
        load("lw08", 1'b0, 1'b0, 32'h08, 32'h600DCAFE);

        // Read and write both high: performed as a store
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h5A5A5A5A);
        #1;
        check("rw.stall", {31'd0, outStall}, 32'd0);
        check("rw.rdata", outReadData, 32'd0);
        tick();
        idle();
        #1;
        check("rw.rdata2", outReadData, 32'd0);
        load("lw50", 1'b0, 1'b0, 32'h50, 32'h5A5A5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
